snn_layer: RTL and testbench
============================

Name: snn_layer

Overview:
- Parametrised single spiking layer: NUM_INPUTS spike inputs fully connected to NUM_NODES leaky integrate-and-fire neurons.
- Neurons use signed run-time-loadable synaptic weights, saturating membrane potentials, a refractory period and winner-take-all lateral inhibition.
- Processes one timestep per step_i request, serially over inputs.
- Sits between the spike encoder(s) and downstream classification/readout logic; replaces fixed-weight neuron + winner selection arrays.

Parameters:
- NUM_INPUTS, 4: number of input spike lines (≥1).
- NUM_NODES, 4: number of neurons (≥1).
- WEIGHT_W, 4: signed synaptic weight width.
- POT_W, 16: signed membrane potential width (> WEIGHT_W).
- THRESHOLD, 1000: signed firing threshold; a neuron fires when pot ≥ THRESHOLD.
- LEAK_SHIFT, 4: leak is pot − (pot >>> LEAK_SHIFT); 0 disables leak.
- REFRACTORY, 3: timesteps a winner is held inactive after firing (0 = none).
- RESET_POT, 0: signed potential loaded on fire/inhibit.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- step_i  in  1  start one timestep (sampled only in IDLE).
- spikes_i  in  NUM_INPUTS  input spikes, latched with step_i.
- wr_en_i  in  1  weight write strobe.
- wr_node_i  in  max(1,$clog2(NUM_NODES))  target neuron.
- wr_input_i  in  max(1,$clog2(NUM_INPUTS))  target input.
- wr_data_i  in  WEIGHT_W  signed weight.
- busy_o  out  1  timestep in progress.
- done_o  out  1  one-cycle pulse: timestep results valid.
- spike_o  out  1  any neuron fired this timestep (valid with done_o).
- winner_o  out  max(1,$clog2(NUM_NODES))  index of winning neuron; held until the next done_o.
- node_spikes_o  out  NUM_NODES  threshold-crossing vector; held until the next done_o.
- pot_o  out  NUM_NODES*POT_W  membrane potentials (node 0 in LSBs), registered.

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high on rst_i.
- Reset: all outputs 0, FSM to IDLE, all potentials 0, refractory counters 0, all weights 0. Reset mid-timestep aborts it with no done_o.
- FSM states: IDLE → ACCUM → FIRE → IDLE.
- IDLE: step_i high at cycle T latches spikes_i; enter ACCUM at T+1.
- ACCUM: input index j = 0..NUM_INPUTS−1, one per cycle.
  - For each non-refractory neuron with latched spike j set: pot += sext(weight[n][j]).
  - Result saturates to [−2^(POT_W−1), 2^(POT_W−1)−1].
  - Refractory neurons do not accumulate.
- FIRE (cycle T+NUM_INPUTS+1), per neuron:
  - Refractory (count > 0): count−1, pot = RESET_POT, not a candidate.
  - Else if pot ≥ THRESHOLD: candidate.
  - Winner = lowest-index candidate: pot = RESET_POT, count = REFRACTORY.
  - Other candidates: pot = RESET_POT, no refractory (inhibited).
  - Non-candidates: leak applied (unless LEAK_SHIFT = 0).
- Results at T+NUM_INPUTS+2:
  - done_o pulses; node_spikes_o = candidate vector; spike_o = |candidates.
  - winner_o updates only when spike_o = 1.
  - FSM is in IDLE and a new step_i is accepted that same cycle.
- busy_o: high from T+1 through T+NUM_INPUTS+1 inclusive.
- step_i outside IDLE: ignored.
- Weight writes:
  - Accepted only when not busy; wr_en_i while busy_o is ignored.
  - Out-of-range indices are ignored.
  - Simultaneous step_i and wr_en_i in IDLE: write applied first; the timestep uses the new weight.
- Arithmetic: leak uses arithmetic shift, so negative potentials decay toward 0 (e.g. −100, shift 2 → −75). Threshold compare is signed.

Test Plan:
- Reset: assert rst_i 2 cycles mid-ACCUM → busy_o=0, done_o never pulses, pot_o=0, node_spikes_o=0; step_i next cycle accepted.
- Latency (NUM_INPUTS=4, THRESHOLD=10, LEAK_SHIFT=0): weight[0][0]=5, step_i with spikes 4'b0001 at T → busy_o high T+1..T+5, done_o only at T+6, pot0=5, spike_o=0.
- Winner/refractory (NUM_NODES=2, REFRACTORY=2): w[0][0]=6, w[1][0]=7, two steps with 4'b0001.
  - Step 2 → node_spikes_o=2'b11, winner_o=0, both pots 0.
  - Step 3 → node0 stays 0, node1=7.
  - Step 4 → node0 still refractory (0), node1=14 fires; winner_o=1.
- Saturation (POT_W=8, THRESHOLD=127): w=−8 on all 4 inputs, 5 steps → pot saturates at −128, not wrap.
- Leak (LEAK_SHIFT=2): pot at 100, step with spikes 0 → 75, next → 57 (100−25, 75−18).
- Busy rules: step_i and wr_en_i (w[0][0]=−3) during ACCUM → ignored; weight unchanged, single done_o; a write in IDLE coincident with step_i takes effect in that step.

Source files
------------

// File: rtl/snn_layer.sv
// Single spiking layer: NUM_INPUTS spike lines fully connected to NUM_NODES leaky
// integrate-and-fire neurons with loadable weights, refractory hold and winner-take-all.
module snn_layer #(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_NODES  = 4,
  parameter int WEIGHT_W   = 4,
  parameter int POT_W      = 16,
  parameter int THRESHOLD  = 1000,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRACTORY = 3,
  parameter int RESET_POT  = 0,
  localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       step_i,
  input  logic [NUM_INPUTS-1:0]      spikes_i,
  input  logic                       wr_en_i,
  input  logic [NW-1:0]              wr_node_i,
  input  logic [IW-1:0]              wr_input_i,
  input  logic [WEIGHT_W-1:0]        wr_data_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       spike_o,
  output logic [NW-1:0]              winner_o,
  output logic [NUM_NODES-1:0]       node_spikes_o,
  output logic [NUM_NODES*POT_W-1:0] pot_o
);
  localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
  localparam logic signed [POT_W-1:0] THR     = POT_W'(THRESHOLD);
  localparam logic signed [POT_W-1:0] RESET_P = POT_W'(RESET_POT);
  localparam logic [RW-1:0]           REF_V   = RW'(REFRACTORY);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_FIRE = 2'd2} state_t;

  state_t                     state_q;
  logic [IW-1:0]              idx_q;
  logic [NUM_INPUTS-1:0]      spk_q;
  logic signed [WEIGHT_W-1:0] w_q   [NUM_NODES][NUM_INPUTS];
  logic signed [POT_W-1:0]    pot_q [NUM_NODES];
  logic [RW-1:0]              ref_q [NUM_NODES];
  logic                       busy_q, done_q, spike_q;
  logic [NW-1:0]              winner_q;
  logic [NUM_NODES-1:0]       nspk_q;

  logic signed [POT_W-1:0]    acc_d  [NUM_NODES];
  logic signed [POT_W-1:0]    leak_d [NUM_NODES];
  logic [NUM_NODES-1:0]       cand_d;
  logic [NW-1:0]              win_d;
  logic                       found_d;
  logic                       wr_ok_d;

  // Sign-extend the weight and clamp the sum to the potential range on overflow.
  function automatic logic signed [POT_W-1:0] sat_add(input logic signed [POT_W-1:0] a,
                                                       input logic signed [WEIGHT_W-1:0] b);
    logic signed [POT_W:0] s;
    s = {a[POT_W-1], a} + {{(POT_W + 1 - WEIGHT_W){b[WEIGHT_W-1]}}, b};
    if (s[POT_W] != s[POT_W-1]) begin
      sat_add = s[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
    end else begin
      sat_add = s[POT_W-1:0];
    end
  endfunction

  assign wr_ok_d = wr_en_i && (state_q == S_IDLE) &&
                   (32'(wr_node_i) < NUM_NODES) && (32'(wr_input_i) < NUM_INPUTS);

  always_comb begin
    win_d   = '0;
    found_d = 1'b0;
    for (int n = 0; n < NUM_NODES; n++) begin
      acc_d[n]  = sat_add(pot_q[n], w_q[n][idx_q]);
      leak_d[n] = (LEAK_SHIFT == 0) ? pot_q[n] : pot_q[n] - (pot_q[n] >>> LEAK_SHIFT);
      cand_d[n] = (ref_q[n] == '0) && (pot_q[n] >= THR);
      if (cand_d[n] && !found_d) begin
        win_d   = NW'(n);
        found_d = 1'b1;
      end else begin
        found_d = found_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NUM_NODES; n++)
        for (int j = 0; j < NUM_INPUTS; j++) w_q[n][j] <= '0;
    end else if (wr_ok_d) begin
      w_q[wr_node_i][wr_input_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      spk_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      spike_q  <= 1'b0;
      winner_q <= '0;
      nspk_q   <= '0;
      for (int n = 0; n < NUM_NODES; n++) begin
        pot_q[n] <= '0;
        ref_q[n] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (step_i) begin
            spk_q   <= spikes_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          for (int n = 0; n < NUM_NODES; n++)
            if (ref_q[n] == '0 && spk_q[idx_q]) pot_q[n] <= acc_d[n];
          if (idx_q == IW'(NUM_INPUTS - 1)) state_q <= S_FIRE;
          else idx_q <= idx_q + IW'(1);
        end
        S_FIRE: begin
          // Refractory nodes count down; all candidates reset, only the winner goes refractory.
          for (int n = 0; n < NUM_NODES; n++) begin
            if (ref_q[n] != '0) begin
              ref_q[n] <= ref_q[n] - RW'(1);
              pot_q[n] <= RESET_P;
            end else if (cand_d[n]) begin
              pot_q[n] <= RESET_P;
              if (NW'(n) == win_d) ref_q[n] <= REF_V;
            end else begin
              pot_q[n] <= leak_d[n];
            end
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          spike_q <= |cand_d;
          nspk_q  <= cand_d;
          if (|cand_d) winner_q <= win_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_NODES; g++) begin : g_pot
    assign pot_o[g*POT_W +: POT_W] = pot_q[g];
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign spike_o       = spike_q;
  assign winner_o      = winner_q;
  assign node_spikes_o = nspk_q;
endmodule

// File: tb/tb_snn_layer.sv
// Self-checking bench for snn_layer: directed scenarios plus random steps against
// a behavioural per-timestep model of the layer.
module tb_snn_layer;
  localparam int NI = 4, NN = 3, WW = 4, PW = 8;
  localparam int TH = 20, LS = 4, RF = 2, RP = 0;

  logic          clk_i = 1'b0, rst_i = 1'b0, step_i = 1'b0, wr_en_i = 1'b0;
  logic [NI-1:0] spikes_i = '0;
  logic [1:0]    wr_node_i = '0, wr_input_i = '0;
  logic [WW-1:0] wr_data_i = '0;
  logic          busy_o, done_o, spike_o;
  logic [1:0]    winner_o;
  logic [NN-1:0] node_spikes_o;
  logic [NN*PW-1:0] pot_o;

  int checks = 0, errors = 0;
  int m_w [NN][NI];
  int m_pot [NN];
  int m_ref [NN];
  int m_win;
  logic [NN-1:0] m_cand;

  snn_layer #(.NUM_INPUTS(NI), .NUM_NODES(NN), .WEIGHT_W(WW), .POT_W(PW), .THRESHOLD(TH),
              .LEAK_SHIFT(LS), .REFRACTORY(RF), .RESET_POT(RP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .step_i(step_i), .spikes_i(spikes_i), .wr_en_i(wr_en_i),
    .wr_node_i(wr_node_i), .wr_input_i(wr_input_i), .wr_data_i(wr_data_i), .busy_o(busy_o),
    .done_o(done_o), .spike_o(spike_o), .winner_o(winner_o), .node_spikes_o(node_spikes_o),
    .pot_o(pot_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NN; n++) begin
      m_pot[n] = 0;
      m_ref[n] = 0;
      for (int j = 0; j < NI; j++) m_w[n][j] = 0;
    end
    m_win = 0;
  endtask

  task automatic model_write(input int wn, input int wi, input logic [WW-1:0] d);
    if (wn < NN && wi < NI) m_w[wn][wi] = int'($signed(d));
  endtask

  // One timestep by the layer's rules, using whole-integer arithmetic.
  task automatic model_step(input logic [NI-1:0] spk);
    int lo, hi, win;
    bit was_ref;
    lo = -(1 << (PW - 1));
    hi = (1 << (PW - 1)) - 1;
    for (int n = 0; n < NN; n++)
      if (m_ref[n] == 0)
        for (int j = 0; j < NI; j++)
          if (spk[j]) begin
            m_pot[n] = m_pot[n] + m_w[n][j];
            if (m_pot[n] > hi) m_pot[n] = hi;
            if (m_pot[n] < lo) m_pot[n] = lo;
          end
    m_cand = '0;
    win = -1;
    for (int n = 0; n < NN; n++) begin
      m_cand[n] = (m_ref[n] == 0) && (m_pot[n] >= TH);
      if (m_cand[n] && win < 0) win = n;
    end
    for (int n = 0; n < NN; n++) begin
      was_ref = (m_ref[n] > 0);
      if (was_ref) begin
        m_ref[n]--;
        m_pot[n] = RP;
      end else if (m_cand[n]) begin
        m_pot[n] = RP;
        if (n == win) m_ref[n] = RF;
      end else if (LS > 0) begin
        m_pot[n] = m_pot[n] - (m_pot[n] >>> LS);
      end
    end
    if (win >= 0) m_win = win;
  endtask

  function automatic logic [NN*PW-1:0] model_pots();
    logic [NN*PW-1:0] v;
    logic [31:0] p;
    for (int n = 0; n < NN; n++) begin
      p = m_pot[n];
      v[n*PW +: PW] = p[PW-1:0];
    end
    return v;
  endfunction

  task automatic wr(input int wn, input int wi, input logic [WW-1:0] d);
    @(negedge clk_i);
    wr_en_i = 1'b1; wr_node_i = 2'(wn); wr_input_i = 2'(wi); wr_data_i = d;
    @(negedge clk_i);
    wr_en_i = 1'b0;
    model_write(wn, wi, d);
  endtask

  // Issue one step (optionally with a coincident write, optionally poking step/write mid-ACCUM).
  task automatic do_step(input logic [NI-1:0] spk, input bit co_wr, input int wn, input int wi,
                         input logic [WW-1:0] wd, input bit inject);
    int c;
    bit busy_ok, early_done;
    @(negedge clk_i);
    step_i = 1'b1; spikes_i = spk;
    if (co_wr) begin
      wr_en_i = 1'b1; wr_node_i = 2'(wn); wr_input_i = 2'(wi); wr_data_i = wd;
      model_write(wn, wi, wd);
    end
    @(negedge clk_i);
    step_i = 1'b0; wr_en_i = 1'b0; spikes_i = '0;
    c = 1; busy_ok = 1'b1; early_done = 1'b0;
    while (!done_o && c < 20) begin
      if (!busy_o) busy_ok = 1'b0;
      if (inject && c == 2) begin
        step_i = 1'b1; spikes_i = 4'b1111;
        wr_en_i = 1'b1; wr_node_i = 2'd0; wr_input_i = 2'd0; wr_data_i = 4'hD;
      end else begin
        step_i = 1'b0; wr_en_i = 1'b0;
      end
      @(negedge clk_i);
      c++;
    end
    step_i = 1'b0; wr_en_i = 1'b0;
    chk("latency", 32'(c), 32'(NI + 2));
    chk("busy_window", {31'd0, busy_ok}, 32'd1);
    chk("busy_low_at_done", {31'd0, busy_o}, 32'd0);
    model_step(spk);
    chk("node_spikes", 32'(node_spikes_o), 32'(m_cand));
    chk("spike_o", {31'd0, spike_o}, {31'd0, |m_cand});
    chk("winner", 32'(winner_o), 32'(m_win));
    chk("pots", 32'(pot_o), 32'(model_pots()));
    @(negedge clk_i);
    if (done_o) early_done = 1'b1;
    chk("done_single", {31'd0, early_done}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  initial begin
    bit seen_done;
    logic [NI-1:0] rs;
    model_reset();
    do_reset();
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_pots", 32'(pot_o), 32'd0);
    chk("reset_nspk", 32'(node_spikes_o), 32'd0);

    // Latency and basic accumulation.
    wr(0, 0, 4'd5);
    do_step(4'b0001, 1'b0, 0, 0, 4'd0, 1'b0);
    chk("lat_pot0", 32'(pot_o[7:0]), 32'd5);
    chk("lat_spike", {31'd0, spike_o}, 32'd0);

    // Reset in the middle of ACCUM.
    wr(1, 1, 4'd7);
    @(negedge clk_i);
    step_i = 1'b1; spikes_i = 4'b1111;
    @(negedge clk_i);
    step_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      if (done_o) seen_done = 1'b1;
    end
    rst_i = 1'b0;
    model_reset();
    for (int k = 0; k < NI + 3; k++) begin
      if (done_o) seen_done = 1'b1;
      if (k == 0) begin
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_pots", 32'(pot_o), 32'd0);
        chk("midrst_nspk", 32'(node_spikes_o), 32'd0);
      end
      @(negedge clk_i);
    end
    chk("midrst_no_done", {31'd0, seen_done}, 32'd0);
    do_step(4'b0001, 1'b0, 0, 0, 4'd0, 1'b0);

    // Winner-take-all and refractory hold.
    do_reset();
    wr(0, 0, 4'd7);
    wr(1, 0, 4'd7);
    for (int s = 1; s <= 6; s++) begin
      do_step(4'b0001, 1'b0, 0, 0, 4'd0, 1'b0);
      if (s == 3) begin
        chk("wta_s3_nspk", 32'(node_spikes_o), 32'h3);
        chk("wta_s3_winner", 32'(winner_o), 32'd0);
        chk("wta_s3_pots", 32'(pot_o[15:0]), 32'd0);
      end
      if (s == 4) chk("wta_s4_pots", 32'(pot_o[15:0]), 32'h0700);
      if (s == 6) begin
        chk("wta_s6_nspk", 32'(node_spikes_o), 32'h2);
        chk("wta_s6_winner", 32'(winner_o), 32'd1);
      end
    end

    // Negative saturation on node 2.
    do_reset();
    for (int j = 0; j < NI; j++) wr(2, j, 4'h8);
    for (int s = 0; s < 5; s++) do_step(4'b1111, 1'b0, 0, 0, 4'd0, 1'b0);
    chk("sat_pot2", 32'(pot_o[23:16]), 32'h88);

    // Negative leak decays toward zero.
    do_reset();
    wr(1, 0, 4'h8);
    do_step(4'b0001, 1'b0, 0, 0, 4'd0, 1'b0);
    chk("leak_a", 32'(pot_o[15:8]), 32'hF9);
    do_step(4'b0000, 1'b0, 0, 0, 4'd0, 1'b0);
    chk("leak_b", 32'(pot_o[15:8]), 32'hFA);

    // Busy rules and write coincident with step.
    do_reset();
    wr(0, 0, 4'd4);
    do_step(4'b0001, 1'b0, 0, 0, 4'd0, 1'b1);
    chk("busy_wr_ignored", 32'(pot_o[7:0]), 32'd4);
    do_step(4'b0001, 1'b1, 0, 0, 4'hD, 1'b0);
    chk("coincident_wr", 32'(pot_o[7:0]), 32'd1);
    wr(3, 0, 4'd7);
    do_step(4'b0001, 1'b0, 0, 0, 4'd0, 1'b0);

    // Randomised weights, spikes and coincident writes.
    do_reset();
    for (int n = 0; n < NN; n++)
      for (int j = 0; j < NI; j++) wr(n, j, 4'($urandom_range(0, 15)));
    for (int s = 0; s < 40; s++) begin
      rs = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        do_step(rs, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 1'b0);
      else
        do_step(rs, 1'b0, 0, 0, 4'd0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
